// File: rtl/axi4_types_pkg.sv
// Shared AXI4 type definitions: response codes, protection attributes and
// AXI4-Lite data/strobe constants with a byte-merge helper.
package axi4_types;

  localparam int unsigned AXI4L_DATA_W = 32;
  localparam int unsigned AXI4L_STRB_W = 4;

  typedef enum logic [1:0] {
    AXI4_RESP_OKAY   = 2'b00,
    AXI4_RESP_EXOKAY = 2'b01,
    AXI4_RESP_SLVERR = 2'b10,
    AXI4_RESP_DECERR = 2'b11
  } axi4_resp_el;

  // AxPROT bit order: [2] instruction, [1] non-secure, [0] privileged
  typedef struct packed {
    logic instr;
    logic nonsecure;
    logic privileged;
  } axi4_prot_typel;

  function automatic logic [AXI4L_DATA_W-1:0] axi4_strb_merge(
    input logic [AXI4L_DATA_W-1:0] old_word,
    input logic [AXI4L_DATA_W-1:0] new_word,
    input logic [AXI4L_STRB_W-1:0] strb
  );
    logic [AXI4L_DATA_W-1:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < AXI4L_STRB_W; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register responder: NUM_REGS read/write words, independent write
// (AW/W/B) and read (AR/R) state machines, one outstanding transaction each.
module axi4_lite_reg_slave
  import axi4_types::*;
#(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_REGS     = 16,
  parameter bit          REQUIRE_PRIV = 1'b1
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic [2:0]                     s_awprot,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [AXI4L_STRB_W-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic [2:0]                     s_arprot,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  output logic [NUM_REGS-1:0]            reg_wr_o
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_W,
    W_WAIT_AW,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rstate_e;

  // Register array
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Write channel state
  wstate_e               wstate_q, wstate_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  axi4_resp_el           bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [2:0]            awprot_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [AXI4L_STRB_W-1:0] wstrb_q;
  logic [NUM_REGS-1:0]   reg_wr_q, reg_wr_d;

  logic                  aw_hs, w_hs, commit;
  logic [ADDR_WIDTH-1:0] awaddr_eff;
  logic [2:0]            awprot_eff;
  logic [DATA_WIDTH-1:0] wdata_eff;
  logic [AXI4L_STRB_W-1:0] wstrb_eff;
  axi4_prot_typel        prot_s;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range;

  // Read channel state
  rstate_e               rstate_q, rstate_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  axi4_resp_el           rresp_q, rresp_d;
  logic                  ar_hs;
  logic [IDX_W-1:0]      r_idx;

  logic                  unused_bits;

  assign aw_hs = s_awvalid & awready_q;
  assign w_hs  = s_wvalid  & wready_q;
  assign ar_hs = s_arvalid & arready_q;

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    wstate_d = wstate_q;
    commit   = 1'b0;
    unique case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end else if (aw_hs) begin
          wstate_d = W_WAIT_W;
        end else if (w_hs) begin
          wstate_d = W_WAIT_AW;
        end
      end
      W_WAIT_W: begin
        if (w_hs) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end
      end
      W_WAIT_AW: begin
        if (aw_hs) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end
      end
      W_RESP: begin
        if (s_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase

    awready_d = (wstate_d == W_IDLE) || (wstate_d == W_WAIT_AW);
    wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_WAIT_W);
    bvalid_d  = (wstate_d == W_RESP);
  end

  // On the completing handshake one half comes from the bus, the other from
  // the holding registers captured by the earlier handshake.
  always_comb begin
    awaddr_eff = aw_hs ? s_awaddr : awaddr_q;
    awprot_eff = aw_hs ? s_awprot : awprot_q;
    wdata_eff  = w_hs  ? s_wdata  : wdata_q;
    wstrb_eff  = w_hs  ? s_wstrb  : wstrb_q;
    prot_s     = axi4_prot_typel'(awprot_eff);
    w_idx      = awaddr_eff[ADDR_WIDTH-1:2];
    w_in_range = 32'(w_idx) < NUM_REGS;
  end

  always_comb begin
    regs_d   = regs_q;
    bresp_d  = bresp_q;
    reg_wr_d = '0;
    if (commit) begin
      if (!w_in_range) begin
        bresp_d = AXI4_RESP_DECERR;
      end else if (REQUIRE_PRIV && !prot_s.privileged) begin
        bresp_d = AXI4_RESP_SLVERR;
      end else begin
        bresp_d = AXI4_RESP_OKAY;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
          if (32'(w_idx) == k) begin
            regs_d[k]   = axi4_strb_merge(regs_q[k], wdata_eff, wstrb_eff);
            reg_wr_d[k] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI4_RESP_OKAY;
      awaddr_q  <= '0;
      awprot_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      reg_wr_q  <= '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      reg_wr_q  <= reg_wr_d;
      if (aw_hs) begin
        awaddr_q <= s_awaddr;
        awprot_q <= s_awprot;
      end
      if (w_hs) begin
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  assign r_idx = s_araddr[ADDR_WIDTH-1:2];

  always_comb begin
    rstate_d = rstate_q;
    unique case (rstate_q)
      R_IDLE:  if (ar_hs)    rstate_d = R_RESP;
      R_RESP:  if (s_rready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
    rvalid_d  = (rstate_d == R_RESP);
  end

  // Reads sample regs_q, so a write committing on the same edge is not seen.
  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs) begin
      rdata_d = '0;
      if (32'(r_idx) < NUM_REGS) begin
        rresp_d = AXI4_RESP_OKAY;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
          if (32'(r_idx) == k) rdata_d = regs_q[k];
        end
      end else begin
        rresp_d = AXI4_RESP_DECERR;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= AXI4_RESP_OKAY;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign reg_wr_o  = reg_wr_q;

  always_comb begin
    reg_o = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      reg_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
    end
  end

  // Byte-offset address bits, read protection and non-privilege prot bits
  // carry no meaning for this register file.
  assign unused_bits = ^{s_arprot, s_araddr[1:0], awaddr_eff[1:0],
                         prot_s.instr, prot_s.nonsecure};

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Self-checking bench for axi4_lite_reg_slave: directed scenarios plus random
// traffic compared against a word-array model of the register file.
module tb_axi4_lite_reg_slave;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [11:0]  s_awaddr;
  logic [2:0]   s_awprot;
  logic         s_awvalid;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic         s_wvalid;
  logic         s_bready;
  logic [11:0]  s_araddr;
  logic [2:0]   s_arprot;
  logic         s_arvalid;
  logic         s_rready;

  logic         s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]   s_bresp, s_rresp;
  logic [31:0]  s_rdata;
  logic [511:0] reg_o;
  logic [15:0]  reg_wr_o;

  logic         np_awready, np_wready, np_bvalid, np_arready, np_rvalid;
  logic [1:0]   np_bresp, np_rresp;
  logic [31:0]  np_rdata;
  logic [511:0] np_reg_o;
  logic [15:0]  np_reg_wr_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_p  [16];
  logic [31:0] mdl_np [16];

  axi4_lite_reg_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(16), .REQUIRE_PRIV(1'b1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .reg_o(reg_o), .reg_wr_o(reg_wr_o)
  );

  axi4_lite_reg_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(16), .REQUIRE_PRIV(1'b0)) dut_np (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(np_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(np_wready),
    .s_bresp(np_bresp), .s_bvalid(np_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(np_arready),
    .s_rdata(np_rdata), .s_rresp(np_rresp), .s_rvalid(np_rvalid), .s_rready(s_rready),
    .reg_o(np_reg_o), .reg_wr_o(np_reg_wr_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [511:0] flat(input bit np);
    logic [511:0] f;
    for (int k = 0; k < 16; k++) f[32*k +: 32] = np ? mdl_np[k] : mdl_p[k];
    return f;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 16; k++) begin
      mdl_p[k]  = '0;
      mdl_np[k] = '0;
    end
  endtask

  task automatic model_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] prot,
                             output logic [1:0] ep, output logic [1:0] enp,
                             output logic [15:0] epulse);
    int unsigned idx;
    idx    = 32'(addr) / 4;
    ep     = OKAY;
    enp    = OKAY;
    epulse = '0;
    if (idx >= 16) begin
      ep  = DECERR;
      enp = DECERR;
      return;
    end
    for (int b = 0; b < 4; b++) if (strb[b]) mdl_np[idx][8*b +: 8] = data[8*b +: 8];
    if (prot[0] == 1'b0) begin
      ep = SLVERR;
    end else begin
      for (int b = 0; b < 4; b++) if (strb[b]) mdl_p[idx][8*b +: 8] = data[8*b +: 8];
      epulse = 16'(1) << idx;
    end
  endtask

  task automatic model_read(input logic [11:0] addr, output logic [31:0] ed,
                            output logic [31:0] end_np, output logic [1:0] er);
    int unsigned idx;
    idx = 32'(addr) / 4;
    if (idx >= 16) begin
      ed = '0; end_np = '0; er = DECERR;
    end else begin
      ed = mdl_p[idx]; end_np = mdl_np[idx]; er = OKAY;
    end
  endtask

  // ---------------- bus drivers ----------------
  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [2:0] prot,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output logic [1:0] np_resp,
                           output logic b_first, output logic [15:0] pulse,
                           output int unsigned proto_err);
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; proto_err = 0;
    while (!(aw_done && w_done)) begin
      s_awvalid = !aw_done && (cyc >= aw_dly);
      s_awaddr  = s_awvalid ? addr : 12'($urandom);
      s_awprot  = s_awvalid ? prot : 3'($urandom);
      s_wvalid  = !w_done && (cyc >= w_dly);
      s_wdata   = s_wvalid ? data : $urandom;
      s_wstrb   = s_wvalid ? strb : 4'($urandom);
      if (aw_done && s_awready) proto_err++;
      if (w_done && s_wready) proto_err++;
      aw_fire = s_awvalid && s_awready;
      w_fire  = s_wvalid && s_wready;
      @(negedge aclk);
      aw_done |= aw_fire;
      w_done  |= w_fire;
      cyc++;
      if (cyc > 200) begin
        checks++; errors++;
        $display("FAIL write_handshake_timeout addr=%h got no AW/W acceptance want acceptance", addr);
        break;
      end
    end
    s_awvalid = 0;
    s_wvalid  = 0;
    b_first = s_bvalid;
    resp    = s_bresp;
    np_resp = np_bresp;
    pulse   = reg_wr_o;
    for (int i = 0; i <= b_dly; i++) begin
      if (s_awready !== 1'b0 || s_wready !== 1'b0) proto_err++;
      s_bready = (i == b_dly);
      @(negedge aclk);
      if (reg_wr_o !== '0) proto_err++;
      if (i < b_dly && (s_bvalid !== 1'b1 || s_bresp !== resp)) proto_err++;
    end
    s_bready = 0;
    if (s_bvalid !== 1'b0) proto_err++;
  endtask

  task automatic axi_read(input logic [11:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [31:0] np_data,
                          output logic [1:0] resp, output logic r_first,
                          output int unsigned proto_err);
    bit fired;
    int cyc;
    fired = 0; cyc = 0; proto_err = 0;
    s_arvalid = 1;
    s_araddr  = addr;
    s_arprot  = 3'($urandom);
    while (!fired) begin
      fired = s_arready;
      @(negedge aclk);
      cyc++;
      if (cyc > 200) begin
        checks++; errors++;
        $display("FAIL read_handshake_timeout addr=%h got no AR acceptance want acceptance", addr);
        break;
      end
    end
    s_arvalid = 0;
    s_araddr  = 12'($urandom);
    r_first = s_rvalid;
    data    = s_rdata;
    np_data = np_rdata;
    resp    = s_rresp;
    for (int i = 0; i <= r_dly; i++) begin
      if (s_arready !== 1'b0) proto_err++;
      s_rready = (i == r_dly);
      @(negedge aclk);
      if (i < r_dly && (s_rvalid !== 1'b1 || s_rdata !== data || s_rresp !== resp)) proto_err++;
    end
    s_rready = 0;
    if (s_rvalid !== 1'b0) proto_err++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    aresetn = 0;
    model_clear();
    repeat (3) @(negedge aclk);
    checks++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake got=%b want=00000", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
    end
    checks++;
    if ({s_bresp, s_rresp, s_rdata, reg_wr_o} !== '0 || reg_o !== '0) begin
      errors++;
      $display("FAIL reset_data bresp=%h rresp=%h rdata=%h wr=%h want all zero", s_bresp, s_rresp, s_rdata, reg_wr_o);
    end
    aresetn = 1;
    @(negedge aclk);
    checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready got=%b want=111", {s_awready, s_wready, s_arready});
    end
  endtask

  task automatic test_write_same_cycle();
    logic [1:0] r, rn, er, ern;
    logic bf;
    logic [15:0] pl, epl;
    int unsigned pe;
    axi_write(12'h004, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0, 0, r, rn, bf, pl, pe);
    model_write(12'h004, 32'hDEADBEEF, 4'hF, 3'b001, er, ern, epl);
    checks++;
    if (bf !== 1'b1 || r !== OKAY) begin
      errors++; $display("FAIL same_cycle_b bvalid=%b bresp=%h want 1/%h", bf, r, OKAY);
    end
    checks++;
    if (pl !== 16'h0002 || pe != 0) begin
      errors++; $display("FAIL same_cycle_pulse reg_wr=%h proto_err=%0d want 0002/0", pl, pe);
    end
    checks++;
    if (reg_o[63:32] !== 32'hDEADBEEF || reg_o !== flat(0)) begin
      errors++; $display("FAIL same_cycle_reg reg1=%h want deadbeef", reg_o[63:32]);
    end
  endtask

  task automatic test_aw_first();
    logic [1:0] r, rn, er, ern;
    logic bf;
    logic [15:0] pl, epl;
    int unsigned pe;
    axi_write(12'h008, 32'hFFFFFFFF, 4'hF, 3'b001, 0, 0, 0, r, rn, bf, pl, pe);
    model_write(12'h008, 32'hFFFFFFFF, 4'hF, 3'b001, er, ern, epl);
    axi_write(12'h008, 32'h11223344, 4'h5, 3'b001, 0, 3, 1, r, rn, bf, pl, pe);
    model_write(12'h008, 32'h11223344, 4'h5, 3'b001, er, ern, epl);
    checks++;
    if (pe != 0 || bf !== 1'b1) begin
      errors++; $display("FAIL aw_first_protocol proto_err=%0d bvalid=%b want 0/1", pe, bf);
    end
    checks++;
    if (r !== OKAY || pl !== 16'h0004) begin
      errors++; $display("FAIL aw_first_resp bresp=%h reg_wr=%h want 0/0004", r, pl);
    end
    checks++;
    if (reg_o[95:64] !== 32'hFF22FF44 || reg_o !== flat(0)) begin
      errors++; $display("FAIL aw_first_reg reg2=%h want ff22ff44", reg_o[95:64]);
    end
  endtask

  task automatic test_w_first_decerr();
    logic [1:0] r, rn, er, ern;
    logic bf;
    logic [15:0] pl, epl;
    int unsigned pe;
    axi_write(12'h040, 32'hCAFEF00D, 4'hF, 3'b001, 2, 0, 0, r, rn, bf, pl, pe);
    model_write(12'h040, 32'hCAFEF00D, 4'hF, 3'b001, er, ern, epl);
    checks++;
    if (r !== DECERR || rn !== DECERR || pe != 0) begin
      errors++; $display("FAIL decerr_resp bresp=%h np=%h proto_err=%0d want 3/3/0", r, rn, pe);
    end
    checks++;
    if (pl !== 16'h0000 || reg_o !== flat(0)) begin
      errors++; $display("FAIL decerr_side_effect reg_wr=%h want 0000 and regs unchanged", pl);
    end
  endtask

  task automatic test_priv();
    logic [1:0] r, rn, er, ern;
    logic bf;
    logic [15:0] pl, epl;
    int unsigned pe;
    axi_write(12'h00C, 32'h12345678, 4'hF, 3'b000, 0, 0, 0, r, rn, bf, pl, pe);
    model_write(12'h00C, 32'h12345678, 4'hF, 3'b000, er, ern, epl);
    checks++;
    if (r !== SLVERR || pl !== 16'h0000 || reg_o[127:96] !== 32'h0) begin
      errors++; $display("FAIL priv_slverr bresp=%h reg_wr=%h reg3=%h want 2/0000/0", r, pl, reg_o[127:96]);
    end
    checks++;
    if (rn !== OKAY || np_reg_o[127:96] !== 32'h12345678 || np_reg_o !== flat(1)) begin
      errors++; $display("FAIL nopriv_okay bresp=%h reg3=%h want 0/12345678", rn, np_reg_o[127:96]);
    end
  endtask

  task automatic test_read_stall();
    logic [31:0] d, dn;
    logic [1:0] r;
    logic rf;
    int unsigned pe;
    axi_read(12'h004, 5, d, dn, r, rf, pe);
    checks++;
    if (rf !== 1'b1 || d !== 32'hDEADBEEF || r !== OKAY) begin
      errors++; $display("FAIL read_stall rvalid=%b rdata=%h rresp=%h want 1/deadbeef/0", rf, d, r);
    end
    checks++;
    if (pe != 0) begin
      errors++; $display("FAIL read_stall_stable proto_err=%0d want 0", pe);
    end
    axi_read(12'h3FC, 0, d, dn, r, rf, pe);
    checks++;
    if (rf !== 1'b1 || d !== 32'h0 || r !== DECERR || pe != 0) begin
      errors++; $display("FAIL read_decerr rvalid=%b rdata=%h rresp=%h proto_err=%0d want 1/0/3/0", rf, d, r, pe);
    end
  endtask

  task automatic test_collision();
    logic [1:0] r, rn, er, ern;
    logic bf, rf;
    logic [15:0] pl, epl;
    logic [31:0] d, dn;
    int unsigned pe;
    axi_write(12'h00C, 32'hA5A5A5A5, 4'hF, 3'b001, 0, 0, 0, r, rn, bf, pl, pe);
    model_write(12'h00C, 32'hA5A5A5A5, 4'hF, 3'b001, er, ern, epl);
    s_awvalid = 1; s_awaddr = 12'h00C; s_awprot = 3'b001;
    s_wvalid  = 1; s_wdata  = 32'h0;   s_wstrb  = 4'hF;
    s_arvalid = 1; s_araddr = 12'h00C;
    @(negedge aclk);
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== 32'hA5A5A5A5 || s_bvalid !== 1'b1 || s_bresp !== OKAY) begin
      errors++; $display("FAIL collision_old rvalid=%b rdata=%h bvalid=%b bresp=%h want 1/a5a5a5a5/1/0",
                         s_rvalid, s_rdata, s_bvalid, s_bresp);
    end
    model_write(12'h00C, 32'h0, 4'hF, 3'b001, er, ern, epl);
    s_bready = 1; s_rready = 1;
    @(negedge aclk);
    s_bready = 0; s_rready = 0;
    axi_read(12'h00C, 0, d, dn, r, rf, pe);
    checks++;
    if (d !== 32'h0 || r !== OKAY || reg_o !== flat(0)) begin
      errors++; $display("FAIL collision_new rdata=%h rresp=%h want 0/0", d, r);
    end
  endtask

  task automatic test_reset_mid();
    s_awvalid = 1; s_awaddr = 12'h010; s_awprot = 3'b001;
    s_wvalid  = 1; s_wdata  = 32'h55AA55AA; s_wstrb = 4'hF;
    @(negedge aclk);
    s_awvalid = 0; s_wvalid = 0;
    checks++;
    if (s_bvalid !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre bvalid=%b want 1", s_bvalid);
    end
    #2 aresetn = 0;
    model_clear();
    #1;
    checks++;
    if (s_bvalid !== 1'b0 || reg_o !== '0 || np_reg_o !== '0) begin
      errors++; $display("FAIL reset_mid bvalid=%b reg0..1=%h want 0 and all regs 0", s_bvalid, reg_o[63:0]);
    end
    @(negedge aclk);
    aresetn = 1;
    repeat (2) @(negedge aclk);
    checks++;
    if (s_bvalid !== 1'b0 || s_awready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_after bvalid=%b awready=%b want 0/1", s_bvalid, s_awready);
    end
  endtask

  task automatic test_random();
    logic [1:0] r, rn, er, ern;
    logic bf, rf;
    logic [15:0] pl, epl;
    logic [31:0] d, dn, ed, edn;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    logic [2:0] prot;
    int unsigned pe;
    for (int n = 0; n < 80; n++) begin
      addr = 12'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        prot = 3'($urandom_range(0, 7));
        axi_write(addr, data, strb, prot, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2), r, rn, bf, pl, pe);
        model_write(addr, data, strb, prot, er, ern, epl);
        checks++;
        if (r !== er || rn !== ern || bf !== 1'b1 || pe != 0) begin
          errors++; $display("FAIL rand_write_resp n=%0d addr=%h bresp=%h np=%h bvalid=%b perr=%0d want %h/%h/1/0",
                             n, addr, r, rn, bf, pe, er, ern);
        end
        checks++;
        if (pl !== epl || reg_o !== flat(0) || np_reg_o !== flat(1)) begin
          errors++; $display("FAIL rand_write_regs n=%0d addr=%h reg_wr=%h want %h", n, addr, pl, epl);
        end
      end else begin
        axi_read(addr, $urandom_range(0, 3), d, dn, r, rf, pe);
        model_read(addr, ed, edn, er);
        checks++;
        if (d !== ed || dn !== edn || r !== er || rf !== 1'b1 || pe != 0) begin
          errors++; $display("FAIL rand_read n=%0d addr=%h rdata=%h np=%h rresp=%h perr=%0d want %h/%h/%h/0",
                             n, addr, d, dn, r, pe, ed, edn, er);
        end
      end
    end
  endtask

  initial begin
    s_awaddr = '0; s_awprot = '0; s_awvalid = 0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
    s_araddr = '0; s_arprot = '0; s_arvalid = 0; s_rready = 0;
    test_reset();
    test_write_same_cycle();
    test_aw_first();
    test_w_first_decerr();
    test_priv();
    test_read_stall();
    test_collision();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
